apb_i2s_host: RTL and testbench

//  APB initiator that drives the I2S transceiver register file from the host side.

---
 rtl/apb_i2s_host.sv | 268 ++++++++++++++++++++++++++
 tb/tb_apb_i2s_host.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2s_host.sv
// Host-side APB initiator for the I2S transceiver: cfg/TX streams become APB writes, RX FIFO polls become an RX stream.
// Latency: 2 cycles per APB transfer (SETUP+ACCESS) plus wait states; TX sample to bus >= 4 cycles (status poll + data write).
// Backpressure: one holding entry per direction; cfg_ready only in IDLE, tx_ready while the TX entry is empty. Optional: APB_TIMEOUT_EN.
module apb_i2s_host #(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [31:0] rx_data,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  output logic [3:0]  status_flags,
  output logic        err
);

  // Gap counter: the first IDLE cycle after a fruitless poll already counts as
  // one gap cycle, so POLL_GAP=4 yields a poll every 6 cycles (2 bus + 4 idle).
  localparam int GW       = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int GAP_LOAD = (POLL_GAP > 0) ? (POLL_GAP - 1) : 0;

  localparam logic [31:0] ADDR_CTRL = 32'h0000_0000;
  localparam logic [31:0] ADDR_TX   = 32'h0000_0004;
  localparam logic [31:0] ADDR_RX   = 32'h0000_0008;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_CFG  = 2'd0,
    OP_POLL = 2'd1,
    OP_TXW  = 2'd2,
    OP_RXR  = 2'd3
  } op_t;

  state_t        r_state;
  state_t        w_state_nxt;
  op_t           r_op;
  op_t           w_op_nxt;
  logic          w_launch;
  logic          w_done;
  logic          w_abort;
  logic          r_run;
  logic [GW-1:0] r_gap;
  logic          r_tx_held;
  logic [31:0]   r_tx_data;
  logic          r_rx_held;
  logic [31:0]   r_rx_data;
  logic [31:0]   r_paddr;
  logic          r_pwrite;
  logic [31:0]   r_pwdata;
  logic [3:0]    r_status;
  logic          w_tx_acc;
  logic          w_rx_pop;

  assign w_done   = (r_state == ST_ACCESS) && pready;
  assign w_tx_acc = tx_valid && tx_ready;
  assign w_rx_pop = rx_valid && rx_ready;

`ifdef APB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] r_tcnt;
  logic          r_err;

  assign w_abort = (r_state == ST_ACCESS) && !pready && (r_tcnt == TW'(TIMEOUT - 1));
  assign err     = r_err;

  // Count consecutive stalled ACCESS cycles; cleared whenever the bus moves on.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_tcnt <= '0;
    end else if ((r_state == ST_ACCESS) && !pready && !w_abort) begin
      r_tcnt <= r_tcnt + TW'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  // Sticky timeout flag, only cleared by reset.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end
`else
  // No abort path: ACCESS waits on pready forever. TIMEOUT has no effect here.
  assign w_abort = 1'b0 & (TIMEOUT > 0);
  assign err     = 1'b0;
`endif

  // Outputs are held low for the first cycle out of reset, then follow state.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // State and operation register.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_CFG;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state: config first, then a status poll when there is work to find;
  // a poll chains straight into the data transfer it justified.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_run) begin
          if (cfg_valid) begin
            w_state_nxt = ST_SETUP;
            w_op_nxt    = OP_CFG;
            w_launch    = 1'b1;
          end else if ((r_tx_held || !r_rx_held) && (r_gap == '0)) begin
            w_state_nxt = ST_SETUP;
            w_op_nxt    = OP_POLL;
            w_launch    = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (pready) begin
          w_state_nxt = ST_IDLE;
          if (r_op == OP_POLL) begin
            if (r_tx_held && !prdata[31]) begin
              w_state_nxt = ST_SETUP;
              w_op_nxt    = OP_TXW;
              w_launch    = 1'b1;
            end else if (!r_rx_held && !prdata[28]) begin
              w_state_nxt = ST_SETUP;
              w_op_nxt    = OP_RXR;
              w_launch    = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address, direction and write data are fixed at launch and held to completion.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_launch) begin
      case (w_op_nxt)
        OP_CFG: begin
          r_paddr  <= ADDR_CTRL;
          r_pwrite <= 1'b1;
          r_pwdata <= cfg_data;
        end
        OP_TXW: begin
          r_paddr  <= ADDR_TX;
          r_pwrite <= 1'b1;
          r_pwdata <= r_tx_data;
        end
        OP_RXR: begin
          r_paddr  <= ADDR_RX;
          r_pwrite <= 1'b0;
          r_pwdata <= '0;
        end
        default: begin
          r_paddr  <= ADDR_CTRL;
          r_pwrite <= 1'b0;
          r_pwdata <= '0;
        end
      endcase
    end
  end

  // Poll spacing: reload after a poll that found nothing (or an abort), zero after data moves.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_gap <= '0;
    end else if (w_abort || (w_done && (r_op == OP_POLL) && (w_state_nxt == ST_IDLE))) begin
      r_gap <= GW'(GAP_LOAD);
    end else if (w_done && ((r_op == OP_TXW) || (r_op == OP_RXR))) begin
      r_gap <= '0;
    end else if ((r_state == ST_IDLE) && (r_gap != '0)) begin
      r_gap <= r_gap - GW'(1);
    end
  end

  // TX holding entry: filled by the stream, emptied by a finished or aborted data write.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_tx_held <= 1'b0;
      r_tx_data <= '0;
    end else if (w_tx_acc) begin
      r_tx_held <= 1'b1;
      r_tx_data <= tx_data;
    end else if ((w_done || w_abort) && (r_op == OP_TXW)) begin
      r_tx_held <= 1'b0;
    end
  end

  // RX holding entry: filled by a completed RX read, emptied by the consumer handshake.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_rx_held <= 1'b0;
      r_rx_data <= '0;
    end else if (w_done && (r_op == OP_RXR)) begin
      r_rx_held <= 1'b1;
      r_rx_data <= prdata;
    end else if (w_rx_pop) begin
      r_rx_held <= 1'b0;
    end
  end

  // Keep the status nibble from the most recent completed poll.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_status <= '0;
    end else if (w_done && (r_op == OP_POLL)) begin
      r_status <= prdata[31:28];
    end
  end

  assign psel         = (r_state != ST_IDLE);
  assign penable      = (r_state == ST_ACCESS);
  assign pwrite       = r_pwrite;
  assign paddr        = r_paddr;
  assign pwdata       = r_pwdata;
  assign cfg_ready    = r_run && (r_state == ST_IDLE);
  assign tx_ready     = r_run && !r_tx_held;
  assign rx_valid     = r_rx_held;
  assign rx_data      = r_rx_data;
  assign status_flags = r_status;

endmodule

// File: tb/tb_apb_i2s_host.sv
// Directed bench for apb_i2s_host: cfg write, poll+TX write, Tx_full repolling, RX read/hold, reset mid-transfer.
// The APB slave is a tiny model: status nibble at 0x0, a data word at 0x8, pready driven by the bench.
// Optional timeout checks run when APB_TIMEOUT_EN is defined.
module tb_apb_i2s_host;

  logic        pclk;
  logic        preset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic [3:0]  status_flags;
  logic        err;

  logic [3:0]  status;
  logic [31:0] rx_word;

  int n_assert;
  int n_fail;
  int n_idle;
  int n_txw;
  int n_busy;

  apb_i2s_host #(.POLL_GAP(4), .TIMEOUT(16)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .status_flags(status_flags),
    .err         (err)
  );

  assign prdata = (paddr == 32'h8) ? rx_word : {status, 28'h0};

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Advance until a SETUP phase to the given address is on the bus (bounded).
  task automatic wait_setup(input logic [31:0] addr, input string tag);
    int k;
    k = 0;
    while (!(psel && !penable && paddr == addr) && k < 40) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, (psel && !penable && paddr == addr)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    preset    = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    rx_ready  = 1'b0;
    pready    = 1'b1;
    status    = 4'b0101;
    rx_word   = '0;
    tick();
    tick();

    // Reset state
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_status_flags", status_flags, 0);
    chk("rst_paddr", paddr, 0);

    // Config write: SETUP then ACCESS to 0x0, cfg_ready low exactly 2 cycles
    preset    = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 32'h0000_0013;
    for (int k = 0; k < 20 && !cfg_ready; k++) tick();
    chk("cfg_ready_up", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    chk("cfg_setup_psel", psel, 1);
    chk("cfg_setup_penable", penable, 0);
    chk("cfg_setup_pwrite", pwrite, 1);
    chk("cfg_setup_paddr", paddr, 32'h0);
    chk("cfg_setup_pwdata", pwdata, 32'h13);
    chk("cfg_ready_low1", cfg_ready, 0);
    tick();
    chk("cfg_access_penable", penable, 1);
    chk("cfg_access_pwdata", pwdata, 32'h13);
    chk("cfg_ready_low2", cfg_ready, 0);
    tick();
    chk("cfg_done_psel", psel, 0);
    chk("cfg_ready_back", cfg_ready, 1);

    // TX sample: poll sees 0101, TX write follows immediately
    tx_data  = 32'hA5A5_0001;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_setup(32'h0, "tx_poll_setup");
    chk("tx_poll_read", pwrite, 0);
    chk("tx_ready_held", tx_ready, 0);
    tick();
    tick();
    chk("txw_setup_psel", psel && !penable, 1);
    chk("txw_paddr", paddr, 32'h4);
    chk("txw_pwrite", pwrite, 1);
    chk("txw_pwdata", pwdata, 32'hA5A5_0001);
    chk("txw_status_flags", status_flags, 4'b0101);
    tick();
    chk("txw_access_penable", penable, 1);
    chk("txw_access_pwdata", pwdata, 32'hA5A5_0001);
    tick();
    chk("txw_done_psel", psel, 0);
    chk("txw_tx_ready", tx_ready, 1);

    // Tx_full: repoll every 6 cycles, no TX write until it clears
    status   = 4'b1001;
    tx_data  = 32'h1234_5678;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_setup(32'h0, "full_poll_setup");
    for (int p = 0; p < 2; p++) begin
      n_idle = 0;
      n_txw  = 0;
      for (int i = 1; i <= 6; i++) begin
        tick();
        if (psel && paddr == 32'h4) n_txw++;
        if (i >= 2 && i <= 5 && !psel) n_idle++;
      end
      chk("full_gap_idle", n_idle, 4);
      chk("full_repoll_at_6", {31'b0, (psel && !penable && paddr == 32'h0 && !pwrite)}, 1);
      chk("full_no_txw", n_txw, 0);
    end
    chk("full_status_flags", status_flags, 4'b1001);
    status = 4'b0101;
    tick();
    tick();
    chk("unfull_txw_paddr", paddr, 32'h4);
    chk("unfull_txw_setup", psel && !penable, 1);
    chk("unfull_txw_pwdata", pwdata, 32'h1234_5678);
    tick();
    tick();
    chk("unfull_tx_ready", tx_ready, 1);

    // RX: Rx_empty=0 -> one RX read, then hold until the consumer takes it
    status  = 4'b0100;
    rx_word = 32'hDEAD_BEEF;
    wait_setup(32'h0, "rx_poll_setup");
    tick();
    tick();
    chk("rxr_paddr", paddr, 32'h8);
    chk("rxr_pwrite", pwrite, 0);
    chk("rxr_setup", psel && !penable, 1);
    tick();
    tick();
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data_first", rx_data, 32'hDEAD_BEEF);
    chk("rx_done_psel", psel, 0);
    rx_word = 32'h0BAD_F00D;
    n_busy  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (psel) n_busy++;
    end
    chk("rx_held_no_bus", n_busy, 0);
    chk("rx_data_stable", rx_data, 32'hDEAD_BEEF);
    chk("rx_valid_stable", rx_valid, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_popped", rx_valid, 0);
    wait_setup(32'h8, "rxr_after_pop");
    tick();
    tick();
    chk("rx_valid_second", rx_valid, 1);
    chk("rx_data_second", rx_data, 32'h0BAD_F00D);

`ifdef APB_TIMEOUT_EN
    // Timeout: 16 stalled ACCESS cycles abort; err sticks across a good transfer
    status   = 4'b0101;
    pready   = 1'b0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    wait_setup(32'h0, "to_poll_setup");
    for (int i = 1; i <= 16; i++) tick();
    chk("to_still_access", penable, 1);
    chk("to_err_before", err, 0);
    tick();
    chk("to_aborted_psel", psel, 0);
    chk("to_err_set", err, 1);
    pready = 1'b1;
    wait_setup(32'h0, "to_next_poll");
    tick();
    tick();
    chk("to_next_done", psel, 0);
    chk("to_err_sticky", err, 1);
`endif

    // Reset mid-ACCESS of a TX write
    status   = 4'b0101;
    tx_data  = 32'hCAFE_0002;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_setup(32'h4, "rst_txw_setup");
    pready = 1'b0;
    tick();
    chk("rst_txw_in_access", penable, 1);
    #2 preset = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_tx_ready", tx_ready, 0);
    chk("midrst_err", err, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    pready = 1'b1;
    tick();
    tick();
    preset = 1'b1;
    tick();
    chk("postrst_tx_ready", tx_ready, 1);
    chk("postrst_rx_valid", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
